// File: rtl/redstone_tick_sched.sv
// Tick scheduler for the redstone fabric: issues a registered one-cycle o_tick
// at a programmable period, under host RUN/PAUSE/STEP control, and counts ticks.
module redstone_tick_sched #(
    parameter int CNT_W          = 32,
    parameter int DIV_W          = 24,
    parameter int DEFAULT_PERIOD = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [31:0]      i_cmd_arg,
    input  logic             i_hold,
    input  logic             i_abort,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_tick_count,
    output logic             o_running,
    output logic             o_step_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [2:0] OP_PAUSE       = 3'd0;
    localparam logic [2:0] OP_RUN         = 3'd1;
    localparam logic [2:0] OP_STEP        = 3'd2;
    localparam logic [2:0] OP_SET_PERIOD  = 3'd3;
    localparam logic [2:0] OP_CLEAR_COUNT = 3'd4;

    localparam logic [DIV_W-1:0] P_RST = (DEFAULT_PERIOD == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_PERIOD);

    state_t             r_state,     w_state_n;
    logic [DIV_W-1:0]   r_period,    w_period_n;
    logic [DIV_W-1:0]   r_phase,     w_phase_n;
    logic [31:0]        r_remaining, w_remaining_n;
    logic [CNT_W-1:0]   r_count,     w_count_n;
    logic               r_tick,      w_tick_n;
    logic               r_step_done, w_step_done_n;
    logic               r_zero_pend, w_zero_pend_n;

    logic               w_ready;
    logic               w_accept;
    logic               w_top;
    logic               w_fire;
    logic               w_last;
    logic [DIV_W-1:0]   w_arg_period;

    // A finished STEP keeps the port closed for the cycle its done pulse is visible.
    assign w_ready      = !i_rst && (r_state != S_STEP) && !r_step_done;
    assign w_accept     = i_cmd_valid && w_ready;
    assign w_top        = (r_phase == r_period - DIV_W'(1));
    assign w_fire       = (r_state != S_IDLE) && w_top && !i_hold;
    assign w_last       = (r_state == S_STEP) && (r_remaining == 32'd1);
    assign w_arg_period = i_cmd_arg[DIV_W-1:0];

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        w_state_n     = r_state;
        w_period_n    = r_period;
        w_phase_n     = r_phase;
        w_remaining_n = r_remaining;
        w_count_n     = r_count;
        w_tick_n      = 1'b0;
        w_step_done_n = r_zero_pend;
        w_zero_pend_n = 1'b0;

        if (w_accept && (i_cmd_op <= OP_SET_PERIOD)) begin
            w_phase_n = '0;
            case (i_cmd_op)
                OP_PAUSE: w_state_n = S_IDLE;
                OP_RUN:   w_state_n = S_RUN;
                OP_STEP: begin
                    if (i_cmd_arg == 32'd0) begin
                        w_state_n     = S_IDLE;
                        w_zero_pend_n = 1'b1;
                    end else begin
                        w_state_n     = S_STEP;
                        w_remaining_n = i_cmd_arg;
                    end
                end
                default:  w_period_n = (w_arg_period == '0) ? DIV_W'(1) : w_arg_period;
            endcase
        end else begin
            // Abort loses only to the tick decision that completes the step.
            if ((r_state == S_STEP) && i_abort && !(w_fire && w_last)) begin
                w_state_n     = S_IDLE;
                w_remaining_n = '0;
                w_phase_n     = '0;
            end else if (r_state != S_IDLE) begin
                if (w_fire) begin
                    w_tick_n  = 1'b1;
                    w_phase_n = '0;
                    w_count_n = r_count + CNT_W'(1);
                    if (r_state == S_STEP) begin
                        w_remaining_n = r_remaining - 32'd1;
                        if (w_last) begin
                            w_state_n     = S_IDLE;
                            w_step_done_n = 1'b1;
                        end
                    end
                end else if (!w_top) begin
                    w_phase_n = r_phase + DIV_W'(1);
                end
            end
            if (w_accept && (i_cmd_op == OP_CLEAR_COUNT)) begin
                w_count_n = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_period    <= P_RST;
            r_phase     <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_tick      <= 1'b0;
            r_step_done <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_period    <= w_period_n;
            r_phase     <= w_phase_n;
            r_remaining <= w_remaining_n;
            r_count     <= w_count_n;
            r_tick      <= w_tick_n;
            r_step_done <= w_step_done_n;
            r_zero_pend <= w_zero_pend_n;
        end
    end

    assign o_cmd_ready  = w_ready;
    assign o_tick       = r_tick;
    assign o_tick_count = r_count;
    assign o_running    = (r_state != S_IDLE);
    assign o_step_done  = r_step_done;

endmodule
